// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: requester, memory and status signals shared by the arbiter and its environment
interface unified_mem_arbiter_if #(parameter int AW = 32);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_rdata;
  logic          if_ready;
  logic          dm_req;
  logic          dm_we;
  logic [2:0]    dm_func3;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic [31:0]   dm_rdata;
  logic          dm_ready;
  logic          mem_en;
  logic          mem_we;
  logic [2:0]    mem_func3;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          busy;
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_func3, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_func3, mem_addr, mem_wdata, busy
  );
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_func3, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_func3, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serialises fetch and data accesses onto one fixed-latency memory with bounded fetch starvation
module unified_mem_arbiter #(
  parameter int LAT        = 2,
  parameter int MAX_STREAK = 4,
  parameter int AW         = 32
) (
  input logic clk,
  input logic rst,
  unified_mem_arbiter_if.slave bus
);
  localparam int CW = $clog2(LAT + 1);
  localparam int SW = MAX_STREAK > 0 ? $clog2(MAX_STREAK + 1) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
  state_t        r_state, w_next;
  logic [CW-1:0] r_lat_cnt;
  logic [SW-1:0] r_streak;
  logic          r_we;
  logic          w_idle, w_if_win, w_if_gnt, w_dm_gnt, w_done;
  always_comb begin
    w_idle        = !rst && r_state == IDLE;
    w_if_win      = bus.if_req && (!bus.dm_req || (MAX_STREAK != 0 && r_streak == SW'(MAX_STREAK)));
    w_if_gnt      = w_idle && w_if_win;
    w_dm_gnt      = w_idle && bus.dm_req && !w_if_win;
    w_done        = !rst && r_state != IDLE && r_lat_cnt == CW'(LAT);
    w_next        = w_if_gnt ? WAIT_I : w_dm_gnt ? WAIT_D : w_done ? IDLE : r_state;
    bus.mem_en    = w_if_gnt || w_dm_gnt;
    bus.mem_we    = w_dm_gnt && bus.dm_we;
    bus.mem_func3 = w_if_gnt ? 3'b010 : w_dm_gnt ? bus.dm_func3 : 3'b000;
    bus.mem_addr  = w_if_gnt ? bus.if_addr : w_dm_gnt ? bus.dm_addr : AW'(0);
    bus.mem_wdata = w_dm_gnt ? bus.dm_wdata : 32'h0;
    bus.if_ready  = w_done && r_state == WAIT_I;
    bus.dm_ready  = w_done && r_state == WAIT_D;
    bus.if_rdata  = bus.if_ready ? bus.mem_rdata : 32'h0;
    bus.dm_rdata  = bus.dm_ready && !r_we ? bus.mem_rdata : 32'h0;
    bus.busy      = !rst && r_state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_streak  <= '0;
      r_we      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_lat_cnt <= bus.mem_en ? CW'(1) : w_done ? '0 : r_state != IDLE ? r_lat_cnt + 1'b1 : r_lat_cnt;
      if (bus.mem_en) r_we <= bus.mem_we;
      if (w_if_gnt || (w_dm_gnt && !bus.if_req)) r_streak <= '0;
      else if (w_dm_gnt && r_streak != SW'(MAX_STREAK)) r_streak <= r_streak + 1'b1;
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: randomized requesters and memory model with a scheduling reference and scoreboard
module tb_unified_mem_arbiter;
  localparam int LAT = 2;
  localparam int MS  = 2;
  typedef struct {int c; logic [31:0] a; logic we; logic [2:0] f; logic [31:0] d;} mexp_t;
  typedef struct {int c; logic [31:0] d;} rexp_t;
  logic clk = 0;
  logic rst = 1;
  bit kill = 1;
  int p_if = 0, p_dm = 0;
  int cyc = 0, n_checks = 0, n_err = 0;
  bit if_done = 0, dm_done = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  rexp_t rd_q [$];
  mexp_t exp_mem [$];
  rexp_t exp_if [$];
  rexp_t exp_dm [$];
  int free_at = 0, streak = 0;
  bit exp_busy = 0;
  unified_mem_arbiter_if #(.AW(32)) bus();
  unified_mem_arbiter #(.LAT(LAT), .MAX_STREAK(MS), .AW(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", n, cyc, got, exp);
    end
  endtask
  always @(posedge clk) begin
    cyc++;
    #1;
    while (rd_q.size() != 0 && rd_q[0].c < cyc) void'(rd_q.pop_front());
    bus.mem_rdata = (rd_q.size() != 0 && rd_q[0].c == cyc) ? rd_q[0].d : $urandom;
  end
  always @(posedge clk) begin
    #1;
    if (kill) begin
      bus.if_req = 0;
      bus.dm_req = 0;
    end else begin
      if (!bus.if_req || if_done) begin
        bus.if_req  = int'($urandom_range(99)) < p_if;
        bus.if_addr = 32'($urandom_range(15)) << 2;
      end
      if (!bus.dm_req || dm_done) begin
        bus.dm_req   = int'($urandom_range(99)) < p_dm;
        bus.dm_we    = 1'($urandom_range(1));
        bus.dm_func3 = 3'($urandom_range(7));
        bus.dm_addr  = 32'($urandom_range(15)) << 2;
        bus.dm_wdata = $urandom;
      end
    end
  end
  always @(negedge clk) begin
    if_done = bus.if_ready;
    dm_done = bus.dm_ready;
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      else rd_q.push_back('{cyc + LAT, mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'hdeadbeef});
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      exp_if.delete();
      exp_dm.delete();
      free_at  = cyc + 1;
      streak   = 0;
      exp_busy = 0;
    end else begin
      exp_busy = cyc < free_at && cyc >= free_at - LAT;
      if (cyc >= free_at && (bus.if_req || bus.dm_req)) begin
        free_at = cyc + LAT + 1;
        if (bus.if_req && (!bus.dm_req || (MS != 0 && streak == MS))) begin
          exp_mem.push_back('{cyc, bus.if_addr, 1'b0, 3'b010, 32'h0});
          exp_if.push_back('{cyc + LAT, ref_mem[bus.if_addr]});
          streak = 0;
        end else begin
          exp_mem.push_back('{cyc, bus.dm_addr, bus.dm_we, bus.dm_func3, bus.dm_wdata});
          if (bus.dm_we) ref_mem[bus.dm_addr] = bus.dm_wdata;
          exp_dm.push_back('{cyc + LAT, bus.dm_we ? 32'h0 : ref_mem[bus.dm_addr]});
          streak = bus.if_req ? (streak < MS ? streak + 1 : MS) : 0;
        end
      end
    end
  end
  always @(negedge clk) begin
    mexp_t m;
    rexp_t r;
    #1;
    if (bus.mem_en) begin
      if (exp_mem.size() == 0) chk("mem_en_unexpected", bus.mem_en, 0);
      else begin
        m = exp_mem.pop_front();
        chk("mem_cycle", cyc, m.c);
        chk("mem_addr", bus.mem_addr, m.a);
        chk("mem_we", bus.mem_we, m.we);
        chk("mem_func3", bus.mem_func3, m.f);
        chk("mem_wdata", bus.mem_wdata, m.d);
      end
    end else chk("mem_idle_fields", {bus.mem_we, bus.mem_func3, bus.mem_addr, bus.mem_wdata}, 0);
    if (bus.if_ready) begin
      if (exp_if.size() == 0) chk("if_ready_unexpected", bus.if_ready, 0);
      else begin
        r = exp_if.pop_front();
        chk("if_ready_cycle", cyc, r.c);
        chk("if_rdata", bus.if_rdata, r.d);
      end
    end else chk("if_rdata_idle", bus.if_rdata, 0);
    if (bus.dm_ready) begin
      if (exp_dm.size() == 0) chk("dm_ready_unexpected", bus.dm_ready, 0);
      else begin
        r = exp_dm.pop_front();
        chk("dm_ready_cycle", cyc, r.c);
        chk("dm_rdata", bus.dm_rdata, r.d);
      end
    end else chk("dm_rdata_idle", bus.dm_rdata, 0);
    chk("busy", bus.busy, exp_busy);
  end
  task automatic run(input int a, input int b, input int n);
    @(posedge clk);
    p_if = a;
    p_dm = b;
    repeat (n - 1) @(posedge clk);
  endtask
  initial begin
    bit got;
    for (int k = 0; k < 16; k++) begin
      logic [31:0] v;
      v = $urandom;
      mem[32'(k) << 2] = v;
      ref_mem[32'(k) << 2] = v;
    end
    mem[32'h10] = 32'h00500093;
    ref_mem[32'h10] = 32'h00500093;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    kill = 0;
    run(100, 0, 20);
    run(0, 0, 15);
    run(100, 100, 60);
    run(0, 0, 15);
    run(0, 100, 30);
    run(0, 0, 15);
    @(posedge clk);
    p_dm = 100;
    got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      #2;
      got = bus.mem_en;
    end
    chk("dm_grant_before_reset", got, 1);
    @(posedge clk);
    kill = 1;
    p_dm = 0;
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk);
    kill = 0;
    run(0, 0, 10);
    run(60, 60, 3000);
    run(30, 70, 1000);
    run(0, 0, 20);
    @(negedge clk);
    #3;
    chk("if_queue_drained", exp_if.size(), 0);
    chk("dm_queue_drained", exp_dm.size(), 0);
    chk("mem_queue_drained", exp_mem.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
